// File: rtl/bringup_sequencer.sv
// bringup_sequencer: resets the backend, shifts an 8-bit gain frame out serially, then waits for ready with bounded retries
module bringup_sequencer #(
  parameter int SCLK_DIV  = 4,
  parameter int RST_CYC   = 8,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic       i_mainclk,
  input  logic       i_resetbFPGA,
  input  logic       i_cfg_valid,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  input  logic       i_ready,
  output logic       o_cfg_accept,
  output logic       o_resetbAll,
  output logic       o_sclk,
  output logic       o_sdout,
  output logic       o_done,
  output logic       o_error
);
  localparam int CMAX = (TIMEOUT > RST_CYC) ? ((TIMEOUT > SCLK_DIV) ? TIMEOUT : SCLK_DIV)
                                            : ((RST_CYC > SCLK_DIV) ? RST_CYC : SCLK_DIV);
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, RST_HOLD, SHIFT, WAIT_READY, DONE, ERROR} state_t;
  state_t        r_state;
  logic [7:0]    r_frame;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [RW-1:0] r_retry;
  logic          r_sync1;
  logic          r_sync2;
  logic [RW-1:0] w_retry_inc;
  assign w_retry_inc = r_retry + 1'b1;
  // One counter serves reset hold, half-period timing and ready timeout; it reloads on every phase change
  always_ff @(posedge i_mainclk) begin
    if (!i_resetbFPGA) begin
      r_state      <= IDLE;
      r_frame      <= '0;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_retry      <= '0;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      o_cfg_accept <= 1'b0;
      o_resetbAll  <= 1'b0;
      o_sclk       <= 1'b0;
      o_sdout      <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      r_sync1      <= i_ready;
      r_sync2      <= r_sync1;
      o_cfg_accept <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: if (i_cfg_valid) begin
          r_frame      <= {3'b101, i_gainA2, i_gainA1};
          o_cfg_accept <= 1'b1;
          r_retry      <= '0;
          o_done       <= 1'b0;
          o_error      <= 1'b0;
          o_resetbAll  <= 1'b0;
          r_cnt        <= '0;
          r_state      <= RST_HOLD;
        end
        RST_HOLD: if (r_cnt == RST_LAST) begin
          r_state     <= SHIFT;
          o_resetbAll <= 1'b1;
          o_sdout     <= r_frame[7];
          r_cnt       <= '0;
          r_bit       <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        SHIFT: if (r_cnt != DIV_LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt  <= '0;
          o_sclk <= ~o_sclk;
          if (o_sclk && r_bit == 3'd7) begin
            r_state <= WAIT_READY;
            o_sdout <= 1'b0;
          end else if (o_sclk) begin
            r_bit   <= r_bit + 1'b1;
            o_sdout <= r_frame[3'd6 - r_bit];
          end
        end
        WAIT_READY: if (r_sync2) begin
          r_state <= DONE;
          o_done  <= 1'b1;
        end else if (r_cnt != TO_LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt   <= '0;
          r_retry <= w_retry_inc;
          if (w_retry_inc < RETRY_MAX) begin
            r_state     <= RST_HOLD;
            o_resetbAll <= 1'b0;
          end else begin
            r_state <= ERROR;
            o_error <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bringup_sequencer.md
BRINGUP_SEQUENCER -- requirements
Module: bringup_sequencer

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4: main-clock cycles per o_sclk half-period (legal range 2..255).
REQ-002 SHALL have parameter RST_CYC, default 8: cycles o_resetbAll is held low per attempt.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed for synchronized ready to rise after the frame ends.
REQ-004 SHALL have parameter MAX_RETRY, default 3: total attempts before error.
REQ-005 SHALL have port i_mainclk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_resetbFPGA, input, 1 bit: synchronous reset, active-low.
REQ-007 SHALL have port i_cfg_valid, input, 1 bit: configuration request.
REQ-008 SHALL have port i_gainA1, input, 2 bits: stage-1 gain code.
REQ-009 SHALL have port i_gainA2, input, 3 bits: stage-2 gain code.
REQ-010 SHALL have port i_ready, input, 1 bit: backend ready, asynchronous to i_mainclk.
REQ-011 SHALL have port o_cfg_accept, output, 1 bit: one-cycle pulse when a request is captured.
REQ-012 SHALL have port o_resetbAll, output, 1 bit: active-low backend reset.
REQ-013 SHALL have port o_sclk, output, 1 bit: serial configuration clock.
REQ-014 SHALL have port o_sdout, output, 1 bit: serial configuration data.
REQ-015 SHALL have port o_done, output, 1 bit: backend configured and ready.
REQ-016 SHALL have port o_error, output, 1 bit: retries exhausted.

Function
REQ-017 States SHALL be IDLE, RST_HOLD, SHIFT, WAIT_READY, DONE and ERROR.
REQ-018 In IDLE, DONE or ERROR, i_cfg_valid=1 SHALL cause the following, then enter RST_HOLD on the next cycle:
- capture frame = {3'b101, i_gainA2, i_gainA1} (8 bits);
- pulse o_cfg_accept for one cycle;
- clear the retry count, o_done and o_error.
REQ-019 i_cfg_valid SHALL be ignored in RST_HOLD, SHIFT and WAIT_READY (no o_cfg_accept; the captured frame does not change).
REQ-020 RST_HOLD SHALL drive o_resetbAll=0 for exactly RST_CYC cycles, then enter SHIFT; o_resetbAll SHALL be 1 in every other state except IDLE.
REQ-021 SHIFT SHALL send the frame MSB first:
- each bit is driven on o_sdout while o_sclk is low;
- o_sclk rises after SCLK_DIV cycles and falls after a further SCLK_DIV cycles;
- o_sdout changes only together with a falling o_sclk edge or at SHIFT entry;
- total duration is 16*SCLK_DIV cycles with exactly 8 rising edges.
REQ-022 After the 8th falling edge the block SHALL enter WAIT_READY with o_sclk=0 and o_sdout=0.
REQ-023 i_ready SHALL pass through a 2-flop synchronizer; "ready" means the synchronized value is 1.
REQ-024 In WAIT_READY, ready SHALL cause entry to DONE with o_done=1 on the next cycle; any ready sampled before WAIT_READY SHALL be ignored.
REQ-025 If ready is not seen within TIMEOUT cycles of WAIT_READY entry, the retry count SHALL increment. Then:
- if the count is below MAX_RETRY, the block re-enters RST_HOLD using the same frame;
- otherwise it enters ERROR with o_error=1.
REQ-026 In DONE, a later drop of ready SHALL not change o_done; only a new request or reset clears it.
REQ-027 If ready arrives in the same cycle that the timeout expires, ready SHALL take priority and the block SHALL enter DONE.
REQ-028 o_sclk and o_sdout SHALL be 0 in every state except SHIFT.
REQ-029 The retry counter SHALL be ceil(log2(MAX_RETRY+1)) bits wide. The timeout and SCLK counters SHALL saturate or reload and SHALL never wrap silently.

Reset
REQ-030 While i_resetbFPGA=0 on a rising i_mainclk edge, the block SHALL be in IDLE with:
- o_resetbAll=0, o_sclk=0, o_sdout=0;
- o_cfg_accept=0, o_done=0, o_error=0;
- all counters and synchronizer flops cleared.
REQ-031 Reset asserted mid-SHIFT or mid-WAIT_READY SHALL abort the transfer within one cycle; the frame SHALL not resume after reset is released.
REQ-032 After reset is released, IDLE SHALL hold o_resetbAll=0 until the first request is accepted.

Verification
REQ-033 The bench SHALL cover each of these scenarios:
- Nominal: gainA1=2'b10, gainA2=3'b011, i_ready tied to o_resetbAll after 5 cycles -> o_resetbAll low 8 cycles; o_sdout bits 1,0,1,0,1,1,1,0 on the 8 o_sclk rising edges (sclk period 8); o_done=1 within 3 cycles of i_ready rising.
- Timeout with retry: i_ready held 0 for attempt 1, then follows reset on attempt 2 -> two RST_HOLD pulses, o_done=1, o_error=0.
- Exhaustion: i_ready held 0 -> three attempts, then o_error=1 at 3*(8+64+1024) cycles plus state overhead; o_done=0.
- Busy request: i_cfg_valid pulsed during SHIFT with different gains -> no o_cfg_accept; the original frame completes unchanged.
- Mid-frame reset: i_resetbFPGA=0 after the 3rd rising edge -> next cycle o_sclk=0, o_sdout=0, o_resetbAll=0, state IDLE.
- Simultaneous ready and timeout: i_ready timed so that synchronized ready rises on timeout cycle 1024 -> o_done=1, retry count unchanged.
